// File: rtl/mmu_paged.sv
// Paged MMU for the 6809 bus: on-chip task maps, per-page write protection with a fault latch,
// delayed task switch and forced task 0 on vector fetch. All state changes on the falling edge of E.
module mmu_paged #(
    parameter int          TASK_BITS    = 2,
    parameter int          PAGE_BITS    = 4,
    parameter int          PHYS_BITS    = 8,
    parameter logic [15:0] IO_ADDR_MIN  = 16'hFC00,
    parameter logic [15:0] IO_ADDR_MAX  = 16'hFEFF,
    parameter logic [15:0] MMU_BASE     = 16'hFE20,
    parameter int          SWITCH_DELAY = 3
) (
    input  logic                 E,
    input  logic                 nRESET,
    input  logic [15:0]          ADDR,
    input  logic                 RnW,
    input  logic                 BA,
    input  logic                 BS,
    input  logic [7:0]           DATA_in,
    output logic [7:0]           DATA_out,
    output logic                 DATA_oe,
    output logic [PHYS_BITS-1:0] PPAGE,
    output logic                 IO_SEL,
    output logic                 WR_INH,
    output logic                 nIRQ
);

    localparam int NTASK = 1 << TASK_BITS;
    localparam int NPAGE = 1 << PAGE_BITS;

    typedef enum logic [2:0] {
        REG_CTRL    = 3'd0,
        REG_TASK    = 3'd1,
        REG_ACCTASK = 3'd2,
        REG_STATUS  = 3'd3,
        REG_INDEX   = 3'd4,
        REG_MAP     = 3'd5,
        REG_ATTR    = 3'd6,
        REG_RSVD    = 3'd7
    } reg_off_e;

    logic [2:0]           r_ctrl;
    logic [TASK_BITS-1:0] r_task;
    logic [TASK_BITS-1:0] r_acctask;
    logic [TASK_BITS-1:0] r_pend_task;
    logic [TASK_BITS-1:0] r_fault_task;
    logic [PAGE_BITS-1:0] r_index;
    logic [PAGE_BITS-1:0] r_fault_page;
    logic                 r_fault;
    logic [3:0]           r_cnt;
    logic [PHYS_BITS-1:0] r_map [NTASK][NPAGE];
    logic                 r_wp  [NTASK][NPAGE];

    logic [PAGE_BITS-1:0] w_lpage;
    logic [TASK_BITS-1:0] w_eff_task;
    logic                 w_sel;
    logic                 w_wr;
    reg_off_e             w_off;
    logic                 w_status_clr;
    logic                 w_wr_inh;
    logic [7:0]           w_status;
    logic [7:0]           w_rdata;

    assign w_lpage      = ADDR[15 -: PAGE_BITS];
    // Vector fetches always run from task 0 so exception entry has a known map.
    assign w_eff_task   = (!BA && BS) ? '0 : r_task;
    assign IO_SEL       = (ADDR >= IO_ADDR_MIN) && (ADDR <= IO_ADDR_MAX);
    assign w_sel        = (ADDR[15:3] == MMU_BASE[15:3]);
    assign w_wr         = w_sel && !RnW;
    assign w_off        = reg_off_e'(ADDR[2:0]);
    assign w_status_clr = w_wr && (w_off == REG_STATUS) && DATA_in[7];

    assign PPAGE    = (!r_ctrl[0] || IO_SEL) ? PHYS_BITS'(w_lpage) : r_map[w_eff_task][w_lpage];
    assign w_wr_inh = r_ctrl[1] && r_ctrl[0] && !RnW && !IO_SEL && r_wp[w_eff_task][w_lpage];
    assign WR_INH   = w_wr_inh;
    assign nIRQ     = !(r_fault && r_ctrl[2]);
    assign DATA_oe  = E && RnW && w_sel;
    assign DATA_out = w_rdata;

    always_comb begin
        w_status                  = '0;
        w_status[7]               = r_fault;
        w_status[TASK_BITS+3:4]   = r_fault_task;
        w_status[PAGE_BITS-1:0]   = r_fault_page;
    end

    always_comb begin
        w_rdata = '0;
        case (w_off)
            REG_CTRL:    w_rdata = {5'd0, r_ctrl};
            REG_TASK:    w_rdata = 8'(r_task);
            REG_ACCTASK: w_rdata = 8'(r_acctask);
            REG_STATUS:  w_rdata = w_status;
            REG_INDEX:   w_rdata = 8'(r_index);
            REG_MAP:     w_rdata = 8'(r_map[r_acctask][r_index]);
            REG_ATTR:    w_rdata = {7'd0, r_wp[r_acctask][r_index]};
            default:     w_rdata = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(negedge E) begin
        if (!nRESET) begin
            r_ctrl       <= '0;
            r_task       <= '0;
            r_acctask    <= '0;
            r_pend_task  <= '0;
            r_index      <= '0;
            r_fault      <= 1'b0;
            r_fault_task <= '0;
            r_fault_page <= '0;
            r_cnt        <= '0;
        end else begin
            if (w_wr) begin
                case (w_off)
                    REG_CTRL:    r_ctrl    <= DATA_in[2:0];
                    REG_ACCTASK: r_acctask <= DATA_in[TASK_BITS-1:0];
                    REG_INDEX:   r_index   <= DATA_in[PAGE_BITS-1:0];
                    default:     ;
                endcase
            end

            if (w_wr && w_off == REG_TASK) begin
                if (DATA_in[7]) begin
                    r_task <= DATA_in[TASK_BITS-1:0];
                    r_cnt  <= '0;
                end else begin
                    r_pend_task <= DATA_in[TASK_BITS-1:0];
                    r_cnt       <= 4'(SWITCH_DELAY);
                end
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - 4'd1;
                if (r_cnt == 4'd1) r_task <= r_pend_task;
            end

            // A fault coinciding with a STATUS clear wins and is latched as the new first fault.
            if (w_wr_inh) begin
                r_fault <= 1'b1;
                if (!r_fault || w_status_clr) begin
                    r_fault_task <= w_eff_task;
                    r_fault_page <= w_lpage;
                end
            end else if (w_status_clr) begin
                r_fault <= 1'b0;
            end
        end
    end

    for (genvar t = 0; t < NTASK; t++) begin : g_task
        for (genvar p = 0; p < NPAGE; p++) begin : g_page
            // NOTE: the map is flops, not RAM, so it can (and must) reset to the identity mapping.
            always_ff @(negedge E) begin
                if (!nRESET) begin
                    r_map[t][p] <= PHYS_BITS'(p);
                    r_wp[t][p]  <= 1'b0;
                end else if (w_wr && r_acctask == TASK_BITS'(t) && r_index == PAGE_BITS'(p)) begin
                    if (w_off == REG_MAP)  r_map[t][p] <= DATA_in[PHYS_BITS-1:0];
                    if (w_off == REG_ATTR) r_wp[t][p]  <= DATA_in[0];
                end
            end
        end
    end

endmodule

// File: tb/tb_mmu_paged.sv
// Self-checking bench for mmu_paged: directed scenarios then randomized bus traffic,
// all compared against a task-map model that tracks the switch as an absolute edge number.
module tb_mmu_paged;

    logic        E = 1'b0;
    logic        nRESET;
    logic [15:0] ADDR;
    logic        RnW;
    logic        BA;
    logic        BS;
    logic [7:0]  DATA_in;
    logic [7:0]  DATA_out;
    logic        DATA_oe;
    logic [7:0]  PPAGE;
    logic        IO_SEL;
    logic        WR_INH;
    logic        nIRQ;

    int compared   = 0;
    int mismatched = 0;

    always #10 E = ~E;

    mmu_paged dut (
        .E(E), .nRESET(nRESET), .ADDR(ADDR), .RnW(RnW), .BA(BA), .BS(BS),
        .DATA_in(DATA_in), .DATA_out(DATA_out), .DATA_oe(DATA_oe),
        .PPAGE(PPAGE), .IO_SEL(IO_SEL), .WR_INH(WR_INH), .nIRQ(nIRQ)
    );

    // Reference model state.
    logic [2:0]  m_ctrl;
    logic [1:0]  m_task, m_acc, m_pend, m_ftask;
    logic [3:0]  m_index, m_fpage;
    logic        m_fault;
    logic [7:0]  m_map [4][16];
    logic        m_wp  [4][16];
    bit          m_known = 1'b0;
    longint      m_edge = 0;
    longint      m_sw_edge = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] m_eff(input logic ba, input logic bs);
        return (!ba && bs) ? 2'd0 : m_task;
    endfunction

    function automatic logic m_io(input logic [15:0] a);
        return (a >= 16'hFC00) && (a <= 16'hFEFF);
    endfunction

    function automatic logic m_sel(input logic [15:0] a);
        return (a >= 16'hFE20) && (a <= 16'hFE27);
    endfunction

    function automatic logic [7:0] m_ppage(input logic [15:0] a, input logic ba, input logic bs);
        logic [3:0] lp;
        lp = a[15:12];
        if (!m_ctrl[0] || m_io(a)) return {4'd0, lp};
        return m_map[m_eff(ba, bs)][lp];
    endfunction

    function automatic logic m_wrinh(input logic [15:0] a, input logic rnw, input logic ba, input logic bs);
        logic [3:0] lp;
        lp = a[15:12];
        return m_ctrl[1] && m_ctrl[0] && !rnw && !m_io(a) && m_wp[m_eff(ba, bs)][lp];
    endfunction

    function automatic logic [7:0] m_read(input logic [2:0] off);
        case (off)
            3'd0: return {5'd0, m_ctrl};
            3'd1: return {6'd0, m_task};
            3'd2: return {6'd0, m_acc};
            3'd3: return {m_fault, 1'b0, m_ftask, m_fpage};
            3'd4: return {4'd0, m_index};
            3'd5: return m_map[m_acc][m_index];
            3'd6: return {7'd0, m_wp[m_acc][m_index]};
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_edge(input logic [15:0] a, input logic rnw, input logic [7:0] d,
                              input logic ba, input logic bs, input logic rst_n);
        logic fault_now, wr, clr;
        if (!rst_n) begin
            m_ctrl = '0; m_task = '0; m_acc = '0; m_pend = '0; m_index = '0;
            m_fault = 1'b0; m_ftask = '0; m_fpage = '0; m_sw_edge = -1;
            for (int t = 0; t < 4; t++)
                for (int p = 0; p < 16; p++) begin
                    m_map[t][p] = 8'(p);
                    m_wp[t][p]  = 1'b0;
                end
            m_known = 1'b1;
        end else begin
            fault_now = m_wrinh(a, rnw, ba, bs);
            wr  = m_sel(a) && !rnw;
            clr = wr && (a[2:0] == 3'd3) && d[7];
            if (fault_now) begin
                if (!m_fault || clr) begin
                    m_ftask = m_eff(ba, bs);
                    m_fpage = a[15:12];
                end
                m_fault = 1'b1;
            end else if (clr) begin
                m_fault = 1'b0;
            end
            if (wr && a[2:0] == 3'd1) begin
                if (d[7]) begin
                    m_task = d[1:0];
                    m_sw_edge = -1;
                end else begin
                    m_pend = d[1:0];
                    m_sw_edge = m_edge + 3;
                end
            end else if (m_sw_edge == m_edge) begin
                m_task = m_pend;
                m_sw_edge = -1;
            end
            if (wr) begin
                case (a[2:0])
                    3'd0: m_ctrl  = d[2:0];
                    3'd2: m_acc   = d[1:0];
                    3'd4: m_index = d[3:0];
                    3'd5: m_map[m_acc][m_index] = d;
                    3'd6: m_wp[m_acc][m_index]  = d[0];
                    default: ;
                endcase
            end
        end
        m_edge++;
    endtask

    // One E cycle: drive after the falling edge, sample while E is high, then model the next falling edge.
    task automatic cycle(input logic [15:0] a, input logic rnw, input logic [7:0] d,
                         input logic ba, input logic bs, input logic rst_n);
        @(negedge E);
        #1;
        ADDR = a; RnW = rnw; DATA_in = d; BA = ba; BS = bs; nRESET = rst_n;
        @(posedge E);
        #1;
        if (m_known) begin
            check("ppage",   PPAGE,   m_ppage(a, ba, bs));
            check("io_sel",  IO_SEL,  m_io(a));
            check("wr_inh",  WR_INH,  m_wrinh(a, rnw, ba, bs));
            check("nirq",    nIRQ,    !(m_fault && m_ctrl[2]));
            check("data_oe", DATA_oe, rnw && m_sel(a));
            if (rnw && m_sel(a)) check("data_out", DATA_out, m_read(a[2:0]));
        end
        model_edge(a, rnw, d, ba, bs, rst_n);
    endtask

    task automatic rd(input logic [15:0] a);
        cycle(a, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        cycle(a, 1'b0, d, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nRESET = 1'b0; ADDR = 16'h0000; RnW = 1'b1; DATA_in = 8'h00; BA = 1'b1; BS = 1'b0;

        cycle(16'h0000, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        rd(16'h5123);
        check("tp_reset_ppage", PPAGE, 8'h05);
        check("tp_reset_io", IO_SEL, 1'b0);
        rd(16'hFE21);
        check("tp_reset_task", DATA_out, 8'h00);
        check("tp_reset_nirq", nIRQ, 1'b1);

        wr(16'hFE22, 8'h01);
        wr(16'hFE24, 8'h05);
        wr(16'hFE25, 8'hA7);
        wr(16'hFE20, 8'h01);
        wr(16'hFE21, 8'h81);
        rd(16'h5000);
        check("tp_map_a7", PPAGE, 8'hA7);
        rd(16'hFE00);
        check("tp_io_ppage", PPAGE, 8'h0F);
        check("tp_io_sel", IO_SEL, 1'b1);

        cycle(16'hFFFE, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1);
        check("tp_vector_ffe", PPAGE, 8'h0F);
        cycle(16'h5000, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1);
        check("tp_vector_task0", PPAGE, 8'h05);

        wr(16'hFE26, 8'h01);
        wr(16'hFE24, 8'h06);
        wr(16'hFE26, 8'h01);
        wr(16'hFE20, 8'h07);
        wr(16'h5010, 8'h55);
        check("tp_wr_inh", WR_INH, 1'b1);
        rd(16'hFE23);
        check("tp_status_95", DATA_out, 8'h95);
        check("tp_fault_nirq", nIRQ, 1'b0);
        wr(16'h6000, 8'h00);
        check("tp_wr_inh2", WR_INH, 1'b1);
        rd(16'hFE23);
        check("tp_first_fault_wins", DATA_out, 8'h95);
        wr(16'hFE23, 8'h80);
        rd(16'hFE23);
        check("tp_clear_nirq", nIRQ, 1'b1);
        check("tp_clear_status", DATA_out, 8'h15);

        wr(16'hFE21, 8'h80);
        wr(16'hFE21, 8'h02);
        rd(16'hFE21);
        rd(16'hFE21);
        check("tp_delay_e1", DATA_out, 8'h00);
        rd(16'hFE21);
        check("tp_delay_e2", DATA_out, 8'h00);
        rd(16'hFE21);
        check("tp_delay_e3", DATA_out, 8'h02);

        wr(16'hFE21, 8'h80);
        wr(16'hFE21, 8'h02);
        rd(16'hFE21);
        wr(16'hFE21, 8'h03);
        rd(16'hFE21);
        check("tp_restart_e2", DATA_out, 8'h00);
        rd(16'hFE21);
        check("tp_restart_e3", DATA_out, 8'h00);
        rd(16'hFE21);
        check("tp_restart_e4", DATA_out, 8'h00);
        rd(16'hFE21);
        check("tp_restart_e5", DATA_out, 8'h03);

        wr(16'hFE21, 8'h80);
        wr(16'hFE22, 8'h00);
        wr(16'hFE24, 8'h02);
        wr(16'hFE26, 8'h01);
        wr(16'h2000, 8'h00);
        wr(16'hFE21, 8'h01);
        rd(16'hFE21);
        cycle(16'hFE23, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        check("tp_pre_reset_nirq", nIRQ, 1'b0);
        rd(16'hFE21);
        check("tp_rst_task", DATA_out, 8'h00);
        check("tp_rst_nirq", nIRQ, 1'b1);
        rd(16'hFE23);
        check("tp_rst_status", DATA_out, 8'h00);
        for (int i = 0; i < 4; i++) begin
            rd(16'hFE21);
            check("tp_rst_no_switch", DATA_out, 8'h00);
        end

        for (int i = 0; i < 3000; i++) begin
            logic [15:0] a;
            logic        ba, bs, rst_n, rnw;
            logic [7:0]  d;
            a = ($urandom_range(0, 9) < 4) ? (16'hFE20 + 16'($urandom_range(0, 7)))
                                           : 16'($urandom);
            rnw   = 1'($urandom_range(0, 1));
            d     = 8'($urandom);
            ba    = 1'($urandom_range(0, 1));
            bs    = 1'($urandom_range(0, 1));
            rst_n = ($urandom_range(0, 199) != 0);
            cycle(a, rnw, d, ba, bs, rst_n);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
